// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout -- VGA scan-out engine (default 640x480@60 from a 100 MHz clock)
//
// Walks the raster with a divide-by-PIX_DIV pixel enable, issues one
// framebuffer read per visible pixel and drives the VGA pins.
//
// Ports:
//   clk          system clock (single domain)
//   reset        synchronous, active-high
//   fb_rd        framebuffer read strobe, one clk wide, only in the pixel-enable clk
//   fb_addr      linear pixel address y*H_ACTIVE + x (running counter)
//   fb_data      {R,G,B} 4 bits each, valid exactly 1 clk after fb_rd
//   frame_start  one-clk pulse alongside the read of pixel (0,0)
//   VGA_HS_O     horizontal sync, active low
//   VGA_VS_O     vertical sync, active low
//   VGA_R/G/B    colour outputs, forced to 0 while blanking
//
// Build option:
//   VGA_TEST_PATTERN_EN  when defined, colour comes from 8 vertical bars and
//                        fb_rd is held 0 (fb_addr is still generated).
//
// Pipeline: stage 0 registers (fb_rd, fb_addr, frame_start) are loaded one clk
// early so they are visible during the pixel-enable clk itself. The memory
// answers in the following clk, and stage 1 (colour + sync) is loaded at the
// end of that clk, so colour and sync change together. PIX_DIV must be >= 2.
// -----------------------------------------------------------------------------
module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIX_DIV  = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        fb_rd,
   output logic [18:0] fb_addr,
   input  logic [11:0] fb_data,
   output logic        frame_start,
   output logic        VGA_HS_O,
   output logic        VGA_VS_O,
   output logic [3:0]  VGA_R,
   output logic [3:0]  VGA_G,
   output logic [3:0]  VGA_B
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int H_W      = $clog2(H_TOTAL);
   localparam int V_W      = $clog2(V_TOTAL);
   localparam int HS_FIRST = H_ACTIVE + H_FP;
   localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
   localparam int VS_FIRST = V_ACTIVE + V_FP;
   localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

   logic [DIV_W-1:0] div_reg;
   logic [H_W-1:0]   h_reg;
   logic [V_W-1:0]   v_reg;
   logic             active_d_reg;
   logic             hs_n_d_reg;
   logic             vs_n_d_reg;

   logic             pe;
   logic             pre_pe;
   logic             active;
   logic             at_origin;
   logic             hs_n;
   logic             vs_n;
   logic [11:0]      pix_color;

   // pre_pe is the clk before the pixel enable; stage 0 loads there so its
   // outputs line up with the pe clk while h/v still hold the same pixel.
   assign pe        = (div_reg == DIV_W'(PIX_DIV - 1));
   assign pre_pe    = (div_reg == DIV_W'(PIX_DIV - 2));
   assign active    = (h_reg < H_W'(H_ACTIVE)) && (v_reg < V_W'(V_ACTIVE));
   assign at_origin = (h_reg == '0) && (v_reg == '0);
   assign hs_n      = !((h_reg >= H_W'(HS_FIRST)) && (h_reg <= H_W'(HS_LAST)));
   assign vs_n      = !((v_reg >= V_W'(VS_FIRST)) && (v_reg <= V_W'(VS_LAST)));

`ifdef VGA_TEST_PATTERN_EN
   // Bar index tracks h/BAR_W with a small counter instead of a divider.
   localparam int BAR_W  = H_ACTIVE / 8;
   localparam int BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam bit RD_EN  = 1'b0;

   logic [BAR_CW-1:0] bar_cnt_reg;
   logic [2:0]        bar_reg;
   logic [2:0]        bar_d_reg;
   logic              unused_fb_data;

   assign unused_fb_data = ^fb_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         bar_cnt_reg <= '0;
         bar_reg     <= 3'd0;
         bar_d_reg   <= 3'd0;
      end else if (pe) begin
         bar_d_reg <= bar_reg;
         if (h_reg == H_W'(H_TOTAL - 1)) begin
            bar_cnt_reg <= '0;
            bar_reg     <= 3'd0;
         end else if (bar_cnt_reg == BAR_CW'(BAR_W - 1)) begin
            bar_cnt_reg <= '0;
            bar_reg     <= bar_reg + 3'd1;
         end else begin
            bar_cnt_reg <= bar_cnt_reg + BAR_CW'(1);
         end
      end
   end

   assign pix_color = {{4{bar_d_reg[2]}}, {4{bar_d_reg[1]}}, {4{bar_d_reg[0]}}};
`else
   localparam bit RD_EN = 1'b1;

   assign pix_color = fb_data;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         div_reg      <= '0;
         h_reg        <= '0;
         v_reg        <= '0;
         fb_rd        <= 1'b0;
         fb_addr      <= '0;
         frame_start  <= 1'b0;
         active_d_reg <= 1'b0;
         hs_n_d_reg   <= 1'b1;
         vs_n_d_reg   <= 1'b1;
         VGA_HS_O     <= 1'b1;
         VGA_VS_O     <= 1'b1;
         VGA_R        <= 4'h0;
         VGA_G        <= 4'h0;
         VGA_B        <= 4'h0;
      end else begin
         div_reg <= pe ? '0 : div_reg + DIV_W'(1);

         // Raster counters and the stage-0 sync/active terms advance on pe.
         if (pe) begin
            if (h_reg == H_W'(H_TOTAL - 1)) begin
               h_reg <= '0;
               v_reg <= (v_reg == V_W'(V_TOTAL - 1)) ? '0 : v_reg + V_W'(1);
            end else begin
               h_reg <= h_reg + H_W'(1);
            end
            active_d_reg <= active;
            hs_n_d_reg   <= hs_n;
            vs_n_d_reg   <= vs_n;
         end

         // Stage 0: visible only during the pe clk, hence one clk wide.
         fb_rd       <= pre_pe && RD_EN && active;
         frame_start <= pre_pe && at_origin;

         // Address only moves for visible pixels, so it parks on the last
         // address of the frame during blanking instead of running past it.
         if (pre_pe && active) begin
            fb_addr <= at_origin ? '0 : fb_addr + 19'd1;
         end

         // Stage 1: the clk after pe is when fb_data is valid.
         if (div_reg == '0) begin
            VGA_R    <= active_d_reg ? pix_color[11:8] : 4'h0;
            VGA_G    <= active_d_reg ? pix_color[7:4]  : 4'h0;
            VGA_B    <= active_d_reg ? pix_color[3:0]  : 4'h0;
            VGA_HS_O <= hs_n_d_reg;
            VGA_VS_O <= vs_n_d_reg;
         end
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_scanout -- directed bench for vga_scanout.
// dut_a uses the default 640x480 timing for reset, pixel path and line sync.
// dut_b uses a miniature raster (24x10 total, 16x6 visible) so whole frames,
// vertical sync, frame wrap and a mid-frame reset fit in a short run.
// Pixel whose pe falls in clk c is read in clk c and shown from clk c+2.
// -----------------------------------------------------------------------------
module tb_vga_scanout;

`ifdef VGA_TEST_PATTERN_EN
   localparam bit RD_ON = 1'b0;
`else
   localparam bit RD_ON = 1'b1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_reset = 1'b1;
   logic        a_fb_rd;
   logic [18:0] a_fb_addr;
   logic [11:0] a_fb_data = 12'h000;
   logic        a_fs, a_hs, a_vs;
   logic [3:0]  a_r, a_g, a_b;

   logic        b_reset = 1'b1;
   logic        b_fb_rd;
   logic [18:0] b_fb_addr;
   logic [11:0] b_fb_data;
   logic        b_fs, b_hs, b_vs;
   logic [3:0]  b_r, b_g, b_b;

   vga_scanout dut_a (
      .clk(clk), .reset(a_reset), .fb_rd(a_fb_rd), .fb_addr(a_fb_addr),
      .fb_data(a_fb_data), .frame_start(a_fs), .VGA_HS_O(a_hs), .VGA_VS_O(a_vs),
      .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b)
   );

   vga_scanout #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(4)
   ) dut_b (
      .clk(clk), .reset(b_reset), .fb_rd(b_fb_rd), .fb_addr(b_fb_addr),
      .fb_data(b_fb_data), .frame_start(b_fs), .VGA_HS_O(b_hs), .VGA_VS_O(b_vs),
      .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
   );

   // Framebuffer model for dut_a: data = address[11:0], 1 clk after the read;
   // junk when no read was issued so blanking has something to suppress.
   always @(posedge clk) a_fb_data <= a_fb_rd ? a_fb_addr[11:0] : 12'hABC;
   assign b_fb_data = 12'hFFF;

   int n_checks = 0;
   int n_pass   = 0;
   int a_c      = 0;
   int a_rd_cnt = 0;
   int a_hs_low = 0;
   int b_k      = 0;
   int b_rd_cnt = 0;
   int b_hs_low = 0;
   int b_vs_low = 0;
   int b_fs_cnt = 0;
   int b_bad    = 0;
   int b_lit    = 0;
   logic [18:0] b_max_addr = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %-16s got %0h exp %0h", tag, got, exp);
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected colour of visible pixel (x,y); data is the framebuffer word.
   function automatic logic [11:0] exp_pix(input int x, input int y, input int hact,
                                           input int vact, input int bar_w,
                                           input logic [11:0] data);
      logic [2:0] bar;
      bar = 3'(x / bar_w);
      if (x >= hact || y >= vact) return 12'h000;
`ifdef VGA_TEST_PATTERN_EN
      return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`else
      return data;
`endif
   endfunction

   // Advance n clks, sampling on each falling edge and updating monitors.
   task automatic step(input int n);
      int p;
      logic [11:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (a_fb_rd) a_rd_cnt++;
         if (!a_hs) a_hs_low++;
         if (b_fb_rd) b_rd_cnt++;
         if (!b_hs) b_hs_low++;
         if (!b_vs) b_vs_low++;
         if (b_fs) b_fs_cnt++;
         if (b_fb_addr > b_max_addr) b_max_addr = b_fb_addr;
         if (b_k >= 2) begin
            p = (b_k - 2) / 4;
            e = exp_pix(p % 24, p / 24, 16, 6, 2, 12'hFFF);
            if ({b_r, b_g, b_b} != e) b_bad++;
            if ({b_r, b_g, b_b} != 12'h000) b_lit++;
         end
         b_k++;
      end
   endtask

   task automatic goto_a(input int t);
      step(t - a_c);
      a_c = t;
   endtask

   initial begin
      // ---- dut_a: reset values and first pixel ----
      step(5);
      check("rst_hs",    a_hs, 1);
      check("rst_vs",    a_vs, 1);
      check("rst_rgb",   {a_r, a_g, a_b}, 12'h000);
      check("rst_rd",    a_fb_rd, 0);
      check("rst_fs",    a_fs, 0);
      check("rst_addr",  a_fb_addr, 0);
      a_reset = 1'b0;
      step(2);
      check("pre_first_rd", a_fb_rd, 0);
      step(1);
      check("first_rd",   a_fb_rd, RD_ON);
      check("first_addr", a_fb_addr, 0);
      check("first_fs",   a_fs, 1);
      a_c = 0; a_rd_cnt = 0; a_hs_low = 0;

      // ---- dut_a: pixel path ----
      goto_a(20);
      check("px5_rd",   a_fb_rd, RD_ON);
      check("px5_addr", a_fb_addr, 5);
      goto_a(21);
      check("px5_rd_width", a_fb_rd, 0);
      check("px4_rgb",  {a_r, a_g, a_b}, exp_pix(4, 0, 640, 480, 80, 12'h004));
      goto_a(22);
      check("px5_rgb",  {a_r, a_g, a_b}, exp_pix(5, 0, 640, 480, 80, 12'h005));
      goto_a(321);
      check("px79_rgb", {a_r, a_g, a_b}, exp_pix(79, 0, 640, 480, 80, 12'h04F));
      goto_a(322);
      check("px80_rgb", {a_r, a_g, a_b}, exp_pix(80, 0, 640, 480, 80, 12'h050));
      goto_a(2242);
      check("px560_rgb", {a_r, a_g, a_b}, exp_pix(560, 0, 640, 480, 80, 12'h230));
      goto_a(2561);
      check("px639_rgb", {a_r, a_g, a_b}, exp_pix(639, 0, 640, 480, 80, 12'h27F));
      goto_a(2562);
      check("px640_blank", {a_r, a_g, a_b}, 12'h000);

      // ---- dut_a: horizontal sync edges ----
      goto_a(2625);
      check("hs_before", a_hs, 1);
      goto_a(2626);
      check("hs_fall", a_hs, 0);
      goto_a(3009);
      check("hs_last_low", a_hs, 0);
      goto_a(3010);
      check("hs_rise", a_hs, 1);
      goto_a(3200);
      check("hs_low_clks", a_hs_low, 384);

      // ---- dut_a: pixel (3,2) ----
      goto_a(6412);
      check("px3_2_rd",   a_fb_rd, RD_ON);
      check("px3_2_addr", a_fb_addr, 1283);
      goto_a(6414);
      check("px3_2_rgb",  {a_r, a_g, a_b}, exp_pix(3, 2, 640, 480, 80, 12'h503));
      check("a_rd_count", a_rd_cnt, RD_ON ? 1283 : 0);

      // ---- dut_b: one whole frame ----
      b_reset = 1'b0;
      step(2);
      b_k = 0; b_rd_cnt = 0; b_hs_low = 0; b_vs_low = 0;
      b_fs_cnt = 0; b_bad = 0; b_lit = 0; b_max_addr = '0;
      step(1);
      check("b_first_fs",   b_fs, 1);
      check("b_first_addr", b_fb_addr, 0);
      step(959);
      check("b_rd_count",  b_rd_cnt, RD_ON ? 96 : 0);
      check("b_hs_low",    b_hs_low, 160);
      check("b_vs_low",    b_vs_low, 192);
      check("b_fs_count",  b_fs_cnt, 1);
      check("b_max_addr",  b_max_addr, 95);
      check("b_rgb_bad",   b_bad, 0);
`ifdef VGA_TEST_PATTERN_EN
      check("b_rgb_lit",   b_lit, 336);
`else
      check("b_rgb_lit",   b_lit, 384);
`endif

      // ---- dut_b: frame wrap ----
      step(1);
      check("b_wrap_fs",   b_fs, 1);
      check("b_wrap_addr", b_fb_addr, 0);
      check("b_wrap_rd",   b_fb_rd, RD_ON);

      // ---- dut_b: reset at pixel (10,3) of the second frame ----
      step(328);
      check("b_mid_rd",   b_fb_rd, RD_ON);
      check("b_mid_addr", b_fb_addr, 58);
      check("b_mid_rgb",  {b_r, b_g, b_b}, exp_pix(9, 3, 16, 6, 2, 12'hFFF));
      b_reset = 1'b1;
      step(1);
      check("b_rst_rd",   b_fb_rd, 0);
      check("b_rst_addr", b_fb_addr, 0);
      check("b_rst_fs",   b_fs, 0);
      check("b_rst_rgb",  {b_r, b_g, b_b}, 12'h000);
      check("b_rst_hs",   b_hs, 1);
      check("b_rst_vs",   b_vs, 1);
      b_reset = 1'b0;
      step(2);
      check("b_restart_pre", b_fb_rd, 0);
      step(1);
      check("b_restart_rd",   b_fb_rd, RD_ON);
      check("b_restart_addr", b_fb_addr, 0);
      check("b_restart_fs",   b_fs, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
